// File: rtl/lift_car_controller.sv
// lift_car_controller
// Consumer end of the hall-request interface for a 4-floor car (floors 0..3).
// It takes a one-hot request from the request buffer through the done/qEmpty
// handshake, moves the car one floor at a time toward the target, runs a
// timed door cycle and then reasserts done so the next request can be loaded.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   button_out one-hot request: bit0=1U bit1=2U bit2=3U bit3=2D bit4=3D bit5=4D
//   qEmpty     high when the buffer holds no pending request
//   done       high when idle; the buffer may load button_out on an edge with done=1
//   floor      current floor, 0..3
//   moving     high while travelling
//   dir_up     travel direction, or arrival direction once at the target
//   door_open  high while the door is open
//   req_err    one-cycle pulse when a zero or multi-hot request is captured
module lift_car_controller #(
  parameter int unsigned FLOOR_TICKS = 8,
  parameter int unsigned DOOR_TICKS  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] button_out,
  input  logic       qEmpty,
  output logic       done,
  output logic [1:0] floor,
  output logic       moving,
  output logic       dir_up,
  output logic       door_open,
  output logic       req_err
);

  localparam int unsigned MaxTicks = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int unsigned CntW     = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

  localparam logic [CntW-1:0] FloorLast = CntW'(FLOOR_TICKS - 1);
  localparam logic [CntW-1:0] DoorLast  = CntW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StMove,
    StDoor
  } state_e;

  state_e          state_q, state_d;
  logic            done_q, done_d;
  logic [1:0]      floor_q, floor_d;
  logic            moving_q, moving_d;
  logic            dir_up_q, dir_up_d;
  logic            door_open_q, door_open_d;
  logic            req_err_q, req_err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      target_q, target_d;
  logic            req_up_q, req_up_d;

  // Request decode; anything that is not exactly one-hot is invalid.
  logic       dec_valid;
  logic [1:0] dec_target;
  logic       dec_up;

  always_comb begin
    dec_valid  = 1'b1;
    dec_target = 2'd0;
    dec_up     = 1'b1;
    case (button_out)
      6'b000001: begin dec_target = 2'd0; dec_up = 1'b1; end
      6'b000010: begin dec_target = 2'd1; dec_up = 1'b1; end
      6'b000100: begin dec_target = 2'd2; dec_up = 1'b1; end
      6'b001000: begin dec_target = 2'd1; dec_up = 1'b0; end
      6'b010000: begin dec_target = 2'd2; dec_up = 1'b0; end
      6'b100000: begin dec_target = 2'd3; dec_up = 1'b0; end
      default:   dec_valid = 1'b0;
    endcase
  end

  // One-floor step in the travel direction; a step past either end is held.
  logic [1:0] step_floor;

  always_comb begin
    step_floor = floor_q;
    if (dir_up_q && (floor_q != 2'd3)) begin
      step_floor = floor_q + 2'd1;
    end else if (!dir_up_q && (floor_q != 2'd0)) begin
      step_floor = floor_q - 2'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    floor_d     = floor_q;
    moving_d    = moving_q;
    dir_up_d    = dir_up_q;
    door_open_d = door_open_q;
    req_err_d   = 1'b0;
    cnt_d       = cnt_q;
    target_d    = target_q;
    req_up_d    = req_up_q;

    unique case (state_q)
      StIdle: begin
        done_d = 1'b1;
        if (!qEmpty) begin
          state_d = StLatch;
          done_d  = 1'b0;
        end
      end

      StLatch: begin
        if (!dec_valid) begin
          req_err_d = 1'b1;
          done_d    = 1'b1;
          state_d   = StIdle;
        end else begin
          target_d = dec_target;
          req_up_d = dec_up;
          cnt_d    = '0;
          if (dec_target == floor_q) begin
            state_d     = StDoor;
            door_open_d = 1'b1;
            dir_up_d    = dec_up;
          end else begin
            state_d  = StMove;
            moving_d = 1'b1;
            dir_up_d = (dec_target > floor_q);
          end
        end
      end

      StMove: begin
        if (cnt_q == FloorLast) begin
          cnt_d   = '0;
          floor_d = step_floor;
          if (step_floor == target_q) begin
            moving_d    = 1'b0;
            dir_up_d    = req_up_q;
            door_open_d = 1'b1;
            state_d     = StDoor;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDoor: begin
        if (cnt_q == DoorLast) begin
          cnt_d       = '0;
          door_open_d = 1'b0;
          done_d      = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      done_q      <= 1'b1;
      floor_q     <= 2'd0;
      moving_q    <= 1'b0;
      dir_up_q    <= 1'b1;
      door_open_q <= 1'b0;
      req_err_q   <= 1'b0;
      cnt_q       <= '0;
      target_q    <= 2'd0;
      req_up_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      floor_q     <= floor_d;
      moving_q    <= moving_d;
      dir_up_q    <= dir_up_d;
      door_open_q <= door_open_d;
      req_err_q   <= req_err_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      req_up_q    <= req_up_d;
    end
  end

  assign done      = done_q;
  assign floor     = floor_q;
  assign moving    = moving_q;
  assign dir_up    = dir_up_q;
  assign door_open = door_open_q;
  assign req_err   = req_err_q;

endmodule

// File: tb/tb_lift_car_controller.sv
// Bench for lift_car_controller. A transaction-level model expands every
// accepted request into the full cycle-by-cycle output timeline it must
// produce; a compare process checks the DUT against it on every falling edge.
module tb_lift_car_controller;

  localparam int FT = 8;
  localparam int DT = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] button_out;
  logic       qEmpty;
  logic       done;
  logic [1:0] floor;
  logic       moving;
  logic       dir_up;
  logic       door_open;
  logic       req_err;

  lift_car_controller #(
    .FLOOR_TICKS(FT),
    .DOOR_TICKS (DT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button_out(button_out),
    .qEmpty    (qEmpty),
    .done      (done),
    .floor     (floor),
    .moving    (moving),
    .dir_up    (dir_up),
    .door_open (door_open),
    .req_err   (req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       done;
    logic [1:0] floor;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic       req_err;
  } obs_t;

  obs_t q[$];
  obs_t exp_o = 7'b1000100;  // idle, floor 0, dir_up 1
  int   cur_floor = 0;
  bit   cur_dir = 1'b1;

  function automatic obs_t idle_obs(input logic err);
    obs_t o;
    o.done = 1'b1; o.floor = 2'(cur_floor); o.moving = 1'b0;
    o.dir_up = cur_dir; o.door_open = 1'b0; o.req_err = err;
    return o;
  endfunction

  function automatic int tgt_of(input int idx);
    case (idx)
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 1;
      4: return 2;
      default: return 3;
    endcase
  endfunction

  // Expand one request into the outputs seen after each successive clock edge,
  // starting with the edge that leaves idle.
  function automatic void build(input logic [5:0] b);
    obs_t o;
    int idx, tgt, d, step;
    bit up, travel_up;
    o = idle_obs(1'b0);
    o.done = 1'b0;
    q.push_back(o);
    if ($countones(b) != 1) begin
      q.push_back(idle_obs(1'b1));
      return;
    end
    idx = 0;
    for (int i = 0; i < 6; i++) if (b[i]) idx = i;
    tgt = tgt_of(idx);
    up = (idx < 3);
    travel_up = (tgt > cur_floor);
    d = travel_up ? tgt - cur_floor : cur_floor - tgt;
    step = travel_up ? 1 : -1;
    for (int j = 0; j < FT * d; j++) begin
      o.done = 1'b0; o.floor = 2'(cur_floor + step * (j / FT)); o.moving = 1'b1;
      o.dir_up = travel_up; o.door_open = 1'b0; o.req_err = 1'b0;
      q.push_back(o);
    end
    for (int k = 0; k < DT; k++) begin
      o.done = 1'b0; o.floor = 2'(tgt); o.moving = 1'b0;
      o.dir_up = up; o.door_open = 1'b1; o.req_err = 1'b0;
      q.push_back(o);
    end
    cur_floor = tgt;
    cur_dir = up;
    q.push_back(idle_obs(1'b0));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cur_floor = 0;
      cur_dir = 1'b1;
      exp_o = idle_obs(1'b0);
    end else if (q.size() > 0) begin
      exp_o = q.pop_front();
    end else if (!qEmpty) begin
      build(button_out);
      exp_o = q.pop_front();
    end else begin
      exp_o = idle_obs(1'b0);
    end
  end

  always @(negedge clk) begin
    chk("cycle_outputs", 32'({done, floor, moving, dir_up, door_open, req_err}), 32'(exp_o));
  end

  // ---------------- stimulus ----------------
  // Present a request from idle and return the number of cycles done stayed low.
  task automatic do_req(input logic [5:0] b, output int lat);
    @(negedge clk);
    #1;
    button_out = b;
    qEmpty = 1'b0;
    @(posedge clk);
    #1;
    qEmpty = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (done === 1'b1) break;
      lat++;
      if (lat > 200) begin
        chk("done_timeout", 32'(lat), 32'(0));
        break;
      end
    end
  endtask

  int lat;
  int seen;

  initial begin
    rst_n = 1'b0;
    qEmpty = 1'b1;
    button_out = 6'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_done", 32'(done), 32'(1));
    chk("reset_floor", 32'(floor), 32'(0));
    chk("reset_dir", 32'(dir_up), 32'(1));

    repeat (20) @(negedge clk);
    chk("idle_floor", 32'(floor), 32'(0));

    do_req(6'b100000, lat);
    chk("4D_latency", 32'(lat), 32'(29));
    chk("4D_floor", 32'(floor), 32'(3));
    chk("4D_dir", 32'(dir_up), 32'(0));

    do_req(6'b000001, lat);
    chk("1U_latency", 32'(lat), 32'(29));
    chk("1U_floor", 32'(floor), 32'(0));
    chk("1U_dir", 32'(dir_up), 32'(1));

    do_req(6'b000010, lat);
    chk("2U_latency", 32'(lat), 32'(13));
    do_req(6'b001000, lat);
    chk("2D_same_floor_latency", 32'(lat), 32'(5));
    chk("2D_floor", 32'(floor), 32'(1));
    chk("2D_dir", 32'(dir_up), 32'(0));

    do_req(6'b000000, lat);
    chk("zero_req_latency", 32'(lat), 32'(1));
    chk("zero_req_err", 32'(req_err), 32'(1));
    chk("zero_req_floor", 32'(floor), 32'(1));
    do_req(6'b000110, lat);
    chk("multi_req_latency", 32'(lat), 32'(1));
    chk("multi_req_err", 32'(req_err), 32'(1));
    @(negedge clk);
    chk("err_one_cycle", 32'(req_err), 32'(0));

    // Reset in the middle of travel from floor 1 toward floor 3.
    @(negedge clk);
    #1;
    button_out = 6'b100000;
    qEmpty = 1'b0;
    @(posedge clk);
    #1;
    qEmpty = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (floor === 2'd2) begin
        seen = 1;
        break;
      end
    end
    chk("reached_floor2", 32'(seen), 32'(1));
    repeat (2) @(negedge clk);
    chk("mid_move_moving", 32'(moving), 32'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 32'({done, floor, moving, dir_up, door_open, req_err}),
        32'(7'b1000100));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_done", 32'(done), 32'(1));
    chk("post_rst_floor", 32'(floor), 32'(0));

    // Random traffic, mostly valid one-hot requests with idle gaps.
    for (int n = 0; n < 40; n++) begin
      logic [5:0] b;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 5) == 0) b = 6'($urandom);
      else b = 6'(1 << $urandom_range(0, 5));
      do_req(b, lat);
    end
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
